// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_arbiter_if: read/write request bus with a one-cycle ready completion
// Rev 1.0
// ============================================================================
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rdEn;
  logic              wrEn;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              ready;

  // master issues requests; slave completes them
  modport master (
    output rdEn, wrEn, address, writeData,
    input  readData, ready
  );
  modport slave (
    input  rdEn, wrEn, address, writeData,
    output readData, ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter: shares one SRAM controller between fetch (p0) and MEM (p1)
// Rev 1.0 | optional: SRAM_ARB_ROUND_ROBIN_EN (round-robin ties, else p0 wins)
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  p0,
  sram_arbiter_if.slave  p1,
  sram_arbiter_if.master m
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic w_req0, w_req1, w_win1;

  assign w_req0 = p0.rdEn | p0.wrEn;
  assign w_req1 = p1.rdEn | p1.wrEn;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q = 1 means port 1 was served last, so port 0 takes the next tie
  assign w_win1 = w_req1 & (~w_req0 | ~last_q);
`else
  assign w_win1 = w_req1 & ~w_req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    first_d  = first_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          // a write wins over a read raised together on the same port
          gnt_d   = w_win1;
          wr_d    = w_win1 ? p1.wrEn      : p0.wrEn;
          addr_d  = w_win1 ? p1.address   : p0.address;
          wdata_d = w_win1 ? p1.writeData : p0.writeData;
          first_d = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        first_d = 1'b0;
        // the controller reports ready while idle, so the first cycle is blind
        if (!first_q && m.ready) begin
          if (!wr_q) begin
            if (gnt_q) rdata1_d = m.readData;
            else       rdata0_d = m.readData;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d  = gnt_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m.rdEn      = (state_q == S_BUSY) & ~wr_q;
  assign m.wrEn      = (state_q == S_BUSY) &  wr_q;
  assign m.address   = addr_q;
  assign m.writeData = wdata_q;

  assign p0.ready    = (state_q == S_RESP) & ~gnt_q;
  assign p1.ready    = (state_q == S_RESP) &  gnt_q;
  assign p0.readData = rdata0_q;
  assign p1.readData = rdata1_q;

endmodule
`default_nettype wire
